// File: rtl/gabor_pkg.sv
// Shared types and constants for the Gabor kernel-window fetch path.
package gabor_pkg;

  localparam int KERNEL_SIZE = 5;
  localparam int PAD         = KERNEL_SIZE / 2;
  localparam int DEF_IMG_W   = 512;
  localparam int DEF_IMG_H   = 512;
  localparam int STRIDE      = DEF_IMG_W + 2 * PAD;
  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 8;
  localparam int IDX_W       = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } win_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              tap_last;
    logic              frame_last;
  } tap_t;

endpackage

// File: rtl/gabor_window_fetch_ctrl_tap_fifo2.sv
// Two-entry FIFO holding returned BRAM words with their tap metadata.
module tap_fifo2
  import gabor_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  tap_t       din,
  input  logic       pop,
  output tap_t       dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  tap_t mem [2];
  logic wr_ptr;
  logic rd_ptr;
  logic do_push;
  logic do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage is reset too, so the tap outputs read as zero after reset;
  // at two entries the extra reset fan-out is negligible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gabor_window_fetch_ctrl.sv
// Walks 5x5 windows over the padded image in raster order, issues BRAM reads
// and delivers the returned pixels as a tagged valid/ready tap stream.
module gabor_window_fetch_ctrl
  import gabor_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              tap_valid,
  input  logic              tap_ready,
  output logic [DATA_W-1:0] tap_data,
  output logic [IDX_W-1:0]  tap_idx,
  output logic              tap_last,
  output logic              frame_last
);

  localparam int ROW_STRIDE = IMG_W + 2 * PAD;
  localparam int COL_W      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ROW_STRIDE);
  localparam logic [2:0]        K_LAST   = 3'(KERNEL_SIZE - 1);

  win_state_t        state, state_next;
  logic [2:0]        kc, kr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] row_base, win_base, tap_base, last_addr;

  logic              rd_pending;
  logic [IDX_W-1:0]  meta_idx;
  logic              meta_tap_last, meta_frame_last;

  logic              kc_wrap, kr_wrap, col_wrap, row_wrap;
  logic              window_done, frame_tap;
  logic              issue, pop;
  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_count;
  tap_t              fifo_in, fifo_out;

  assign kc_wrap     = (kc == K_LAST);
  assign kr_wrap     = (kr == K_LAST);
  assign col_wrap    = (col == COL_W'(IMG_W - 1));
  assign row_wrap    = (row == ROW_W'(IMG_H - 1));
  assign window_done = kc_wrap && kr_wrap;
  assign frame_tap   = window_done && col_wrap && row_wrap;

  // A pop this cycle frees its slot in time for a read issued this cycle.
  assign pop   = tap_ready && !fifo_empty;
  assign issue = (state == RUN) && !(fifo_full && !pop) &&
                 (({1'b0, fifo_count} + {2'b0, rd_pending}) < (3'd2 + {2'b0, pop}));

  assign bram_en   = issue;
  assign bram_addr = issue ? (tap_base + ADDR_W'(kc)) : last_addr;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: every output of this block gets a default first, so no path leaves
  // state_next unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (issue && frame_tap) state_next = DRAIN;
      DRAIN:   if (!rd_pending && (fifo_empty || (fifo_count == 2'd1 && pop)))
                 state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kc              <= '0;
      kr              <= '0;
      col             <= '0;
      row             <= '0;
      idx             <= '0;
      row_base        <= '0;
      win_base        <= '0;
      tap_base        <= '0;
      last_addr       <= '0;
      rd_pending      <= 1'b0;
      meta_idx        <= '0;
      meta_tap_last   <= 1'b0;
      meta_frame_last <= 1'b0;
    end else begin
      rd_pending <= issue;
      if (state == IDLE && start) begin
        kc       <= '0;
        kr       <= '0;
        col      <= '0;
        row      <= '0;
        idx      <= '0;
        row_base <= '0;
        win_base <= '0;
        tap_base <= '0;
      end else if (issue) begin
        last_addr       <= bram_addr;
        meta_idx        <= idx;
        meta_tap_last   <= window_done;
        meta_frame_last <= frame_tap;
        idx             <= window_done ? '0 : idx + 1'b1;
        // Address bases advance incrementally: tap_base tracks the current kernel row.
        if (!kc_wrap) begin
          kc <= kc + 3'd1;
        end else begin
          kc <= '0;
          if (!kr_wrap) begin
            kr       <= kr + 3'd1;
            tap_base <= tap_base + STRIDE_A;
          end else begin
            kr <= '0;
            if (!col_wrap) begin
              col      <= col + 1'b1;
              win_base <= win_base + 1'b1;
              tap_base <= win_base + 1'b1;
            end else begin
              col      <= '0;
              row      <= row_wrap ? '0 : row + 1'b1;
              row_base <= row_base + STRIDE_A;
              win_base <= row_base + STRIDE_A;
              tap_base <= row_base + STRIDE_A;
            end
          end
        end
      end
    end
  end

  assign fifo_in = '{data: bram_rdata, idx: meta_idx,
                     tap_last: meta_tap_last, frame_last: meta_frame_last};

  tap_fifo2 u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rd_pending),
    .din   (fifo_in),
    .pop   (pop),
    .dout  (fifo_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tap_valid  = !fifo_empty;
  assign tap_data   = fifo_out.data;
  assign tap_idx    = fifo_out.idx;
  assign tap_last   = fifo_out.tap_last;
  assign frame_last = fifo_out.frame_last;

endmodule

// File: tb/tb_gabor_window_fetch_ctrl.sv
// Directed bench: a 512x512 instance for window addressing, an 8x8 instance
// for complete frames under backpressure, random ready and mid-frame reset.
module tb_gabor_window_fetch_ctrl;
  import gabor_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic              b_start, b_busy, b_done, b_bram_en, b_ready, b_valid, b_last, b_flast;
  logic [ADDR_W-1:0] b_bram_addr;
  logic [DATA_W-1:0] b_rdata, b_data;
  logic [4:0]        b_idx;

  logic              s_start, s_busy, s_done, s_bram_en, s_ready, s_valid, s_last, s_flast;
  logic [ADDR_W-1:0] s_bram_addr;
  logic [DATA_W-1:0] s_rdata, s_data;
  logic [4:0]        s_idx;

  gabor_window_fetch_ctrl #(.IMG_W(512), .IMG_H(512)) u_big (
    .clock(clock), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
    .bram_en(b_bram_en), .bram_addr(b_bram_addr), .bram_rdata(b_rdata),
    .tap_valid(b_valid), .tap_ready(b_ready), .tap_data(b_data), .tap_idx(b_idx),
    .tap_last(b_last), .frame_last(b_flast)
  );

  gabor_window_fetch_ctrl #(.IMG_W(8), .IMG_H(8)) u_small (
    .clock(clock), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
    .bram_en(s_bram_en), .bram_addr(s_bram_addr), .bram_rdata(s_rdata),
    .tap_valid(s_valid), .tap_ready(s_ready), .tap_data(s_data), .tap_idx(s_idx),
    .tap_last(s_last), .frame_last(s_flast)
  );

  // Pixel content is a fixed scramble of the word address.
  function automatic logic [7:0] pix(int a);
    return 8'((a * 37) ^ (a >> 5));
  endfunction

  // Golden address of the n-th tap of a frame of width w, from first principles.
  function automatic int exp_addr(int n, int w);
    int p, t;
    p = n / 25;
    t = n % 25;
    return (p / w + t / 5) * (w + 4) + p % w + t % 5;
  endfunction

  always @(posedge clock) if (b_bram_en) b_rdata <= pix(int'(b_bram_addr));
  always @(posedge clock) if (s_bram_en) s_rdata <= pix(int'(s_bram_addr));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_small_reset_values();
    check("rst_busy", 64'(s_busy), 64'(0));
    check("rst_done", 64'(s_done), 64'(0));
    check("rst_bram_en", 64'(s_bram_en), 64'(0));
    check("rst_bram_addr", 64'(s_bram_addr), 64'(0));
    check("rst_tap_valid", 64'(s_valid), 64'(0));
    check("rst_tap_data", 64'(s_data), 64'(0));
    check("rst_tap_idx", 64'(s_idx), 64'(0));
    check("rst_tap_last", 64'(s_last), 64'(0));
    check("rst_frame_last", 64'(s_flast), 64'(0));
  endtask

  // Runs one 8x8 frame. mode 0: ready high, 1: ready low cycles 10..29, 2: random ready.
  task automatic run_frame(input int mode, input int abort_at, output int xfers, output longint sum);
    int issued, fl_cyc, dones;
    bit finished, stall;
    logic [7:0] held_data;
    logic [4:0] held_idx;
    issued = 0; fl_cyc = -1; dones = 0; finished = 0; stall = 0;
    held_data = '0; held_idx = '0; xfers = 0; sum = 0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(posedge clock); #1;
      s_start = (cyc == 0) || (mode == 0 && (cyc == 500 || cyc == 1603));
      case (mode)
        1:       s_ready = !(cyc >= 10 && cyc < 30);
        2:       s_ready = 1'($urandom_range(0, 1));
        default: s_ready = 1'b1;
      endcase
      @(negedge clock);
      if (cyc == 1) check("busy_after_start", 64'(s_busy), 64'(1));
      if (stall) begin
        check("held_valid", 64'(s_valid), 64'(1));
        check("held_data", 64'(s_data), 64'(held_data));
        check("held_idx", 64'(s_idx), 64'(held_idx));
      end
      if (s_bram_en) begin
        check("addr", 64'(s_bram_addr), 64'(exp_addr(issued, 8)));
        if (issued == 1599) check("final_addr", 64'(s_bram_addr), 64'(143));
        issued++;
      end
      if (mode == 1 && cyc >= 11 && cyc < 30) check("bp_no_read", 64'(s_bram_en), 64'(0));
      if (s_valid && s_ready) begin
        check("tap_data", 64'(s_data), 64'(pix(exp_addr(xfers, 8))));
        check("tap_idx", 64'(s_idx), 64'(xfers % 25));
        check("tap_last", 64'(s_last), 64'(xfers % 25 == 24));
        check("frame_last", 64'(s_flast), 64'(xfers == 1599));
        sum += longint'(s_data);
        if (s_flast) fl_cyc = cyc;
        xfers++;
      end
      check("outstanding_le_2", 64'(issued - xfers <= 2), 64'(1));
      stall     = s_valid && !s_ready;
      held_data = s_data;
      held_idx  = s_idx;
      if (abort_at >= 0 && xfers == abort_at) begin
        s_start = 1'b0;
        return;
      end
      if (dones > 0) begin
        check("busy_after_done", 64'(s_busy), 64'(0));
        check("done_one_cycle", 64'(s_done), 64'(0));
        finished = 1;
      end else if (s_done) begin
        dones++;
        check("done_after_last", 64'(cyc - fl_cyc), 64'(1));
        check("done_xfers", 64'(xfers), 64'(1600));
        check("busy_with_done", 64'(s_busy), 64'(1));
        if (mode == 0) check("done_cycle", 64'(cyc), 64'(1603));
      end
    end
    s_start = 1'b0;
    check("frame_finished", 64'(finished), 64'(1));
  endtask

  initial begin
    int issued, xf, x3, x4, x5, x6;
    longint s3, s4, s5, s6, gsum;

    reset = 1'b1; b_start = 1'b0; s_start = 1'b0; b_ready = 1'b1; s_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_small_reset_values();
    check("rst_big_bram_en", 64'(b_bram_en), 64'(0));
    check("rst_big_valid", 64'(b_valid), 64'(0));
    reset = 1'b0;

    // T1/T2: 512x512 window addressing up to the first window of row 1.
    @(posedge clock); #1 b_start = 1'b1;
    @(posedge clock); #1 b_start = 1'b0;
    issued = 0; xf = 0;
    for (int cyc = 0; cyc < 13000 && issued < 12825; cyc++) begin
      @(negedge clock);
      if (b_bram_en) begin
        check("big_addr", 64'(b_bram_addr), 64'(exp_addr(issued, 512)));
        if (issued == 4)     check("big_addr_4", 64'(b_bram_addr), 64'(4));
        if (issued == 5)     check("big_addr_516", 64'(b_bram_addr), 64'(516));
        if (issued == 24)    check("big_addr_2068", 64'(b_bram_addr), 64'(2068));
        if (issued == 25)    check("big_pix01_start", 64'(b_bram_addr), 64'(1));
        if (issued == 12800) check("big_pix10_start", 64'(b_bram_addr), 64'(516));
        issued++;
      end
      if (b_valid && xf < 50) begin
        check("big_data", 64'(b_data), 64'(pix(exp_addr(xf, 512))));
        check("big_idx", 64'(b_idx), 64'(xf % 25));
        check("big_last", 64'(b_last), 64'(xf % 25 == 24));
        check("big_frame_last", 64'(b_flast), 64'(0));
        xf++;
      end
      @(posedge clock); #1;
    end
    check("big_issue_budget", 64'(issued), 64'(12825));

    // T3: full 8x8 frame with ready high; extra starts while busy and during DONE.
    run_frame(0, -1, x3, s3);
    check("t3_xfers", 64'(x3), 64'(1600));

    // T4: backpressure window.
    gsum = 0;
    for (int n = 0; n < 1600; n++) gsum += longint'(pix(exp_addr(n, 8)));
    run_frame(1, -1, x4, s4);
    check("t4_xfers", 64'(x4), 64'(1600));
    check("t4_sum", 64'(s4), 64'(gsum));

    // T5: random ready.
    void'($urandom(1));
    run_frame(2, -1, x5, s5);
    check("t5_xfers", 64'(x5), 64'(1600));
    check("t5_sum", 64'(s5), 64'(gsum));

    // T6: asynchronous reset after 700 taps, then a clean restart.
    run_frame(0, 700, x6, s6);
    check("t6_abort_point", 64'(x6), 64'(700));
    #2 reset = 1'b1;
    #1 check_small_reset_values();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t6_no_done_in_reset", 64'(s_done), 64'(0));
    end
    reset = 1'b0;
    @(negedge clock);
    check("t6_idle_done", 64'(s_done), 64'(0));
    check("t6_idle_busy", 64'(s_busy), 64'(0));
    run_frame(0, -1, x6, s6);
    check("t6_xfers", 64'(x6), 64'(1600));
    check("t6_sum_vs_t3", 64'(s6), 64'(s3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
